// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the DM-to-AXI bridge state type.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_DONE
    } dm_state_e;

endpackage

// File: rtl/cpu_dm_axi_master.sv
// Bridges the core's SRAM-style data-memory port to single-beat AXI4 reads/writes,
// stalling the core until each transaction's response has been taken.
module cpu_dm_axi_master
    import axi_pkg::*;
#(
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0]   MASTER_ID  = ID_WIDTH'(1),
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_ceb,
    input  logic                    cpu_web,
    input  logic [DATA_WIDTH/8-1:0] cpu_bweb,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_stall,
    output logic                    resp_err,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    dm_state_e state, next_state;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;

    // Single-beat transfers: IDs, lengths and LAST are never inspected.
    logic unused_inputs;
    assign unused_inputs = ^{rid, bid, rlast};

    wire req = !cpu_ceb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (req) next_state = cpu_web ? S_RD_ADDR : S_WR_ADDR;
            S_RD_ADDR: if (arready) next_state = S_RD_DATA;
            S_RD_DATA: if (rvalid)  next_state = S_DONE;
            S_WR_ADDR: if (awready) next_state = S_WR_DATA;
            S_WR_DATA: if (wready)  next_state = S_WR_RESP;
            S_WR_RESP: if (bvalid)  next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // resp_err defaults low each cycle so a captured error shows only during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            cpu_rdata <= '0;
            resp_err  <= 1'b0;
        end else begin
            resp_err <= 1'b0;
            if (state == S_IDLE && req) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                strb_q  <= ~cpu_bweb;
            end
            if (state == S_RD_DATA && rvalid) begin
                cpu_rdata <= rdata;
                resp_err  <= (rresp != RESP_OKAY);
            end
            if (state == S_WR_RESP && bvalid)
                resp_err <= (bresp != RESP_OKAY);
        end
    end

    // Valids decode straight from the state register, so they stay up until ready.
    assign arvalid = (state == S_RD_ADDR);
    assign rready  = (state == S_RD_DATA);
    assign awvalid = (state == S_WR_ADDR);
    assign wvalid  = (state == S_WR_DATA);
    assign bready  = (state == S_WR_RESP);

    assign arid    = MASTER_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign awid    = MASTER_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign wdata   = wdata_q;
    assign wstrb   = strb_q;
    assign wlast   = wvalid;

    assign cpu_stall = (state == S_IDLE && req) || (state != S_IDLE && state != S_DONE);

endmodule

// File: tb/tb_cpu_dm_axi_master.sv
// Directed bench for cpu_dm_axi_master: a transaction table driven through a
// cycle-level AXI slave model, plus hand sequences for held requests and mid-write reset.
module tb_cpu_dm_axi_master;

    logic        clk, rst;
    logic        cpu_ceb, cpu_web;
    logic [3:0]  cpu_bweb;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, resp_err;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    cpu_dm_axi_master dut (
        .clk(clk), .rst(rst),
        .cpu_ceb(cpu_ceb), .cpu_web(cpu_web), .cpu_bweb(cpu_bweb), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a_hold: cycles AR/AW valid stays up (ready on the last one); w_hold likewise for W;
    // d_wait: cycles RREADY/BREADY is up before the slave raises RVALID/BVALID.
    typedef struct {
        logic        web;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  bweb;
        logic [31:0] rsp_data;
        logic [1:0]  rsp;
        int          a_hold;
        int          w_hold;
        int          d_wait;
        int          exp_stall;
        logic [3:0]  exp_strb;
        logic        exp_err;
    } vec_t;

    vec_t        vec [6];
    int          tests = 0, fails = 0;
    logic [31:0] exp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_slave();
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    task automatic do_txn(input vec_t v);
        int   stall_n = 0, a_cnt = 0, w_cnt = 0, d_cnt = 0;
        int   a_hs = 0, w_hs = 0, d_hs = 0;
        logic addr_bad = 0, data_bad = 0;
        logic [3:0] strb_seen = 0;
        bit   done = 0;
        cpu_web = v.web; cpu_addr = v.addr; cpu_wdata = v.wdat; cpu_bweb = v.bweb; cpu_ceb = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (cpu_stall) stall_n++;
            else if (stall_n > 0) done = 1;
            if (!done) begin
                arready = arvalid && (a_cnt + 1 >= v.a_hold);
                awready = awvalid && (a_cnt + 1 >= v.a_hold);
                if (arvalid && araddr !== v.addr) addr_bad = 1;
                if (awvalid && awaddr !== v.addr) addr_bad = 1;
                if (arvalid || awvalid) a_cnt++;
                if ((arvalid && arready) || (awvalid && awready)) a_hs++;
                wready = wvalid && (w_cnt + 1 >= v.w_hold);
                if (wvalid) begin
                    w_cnt++;
                    if (wdata !== v.wdat || wlast !== 1'b1) data_bad = 1;
                    strb_seen = wstrb;
                end
                if (wvalid && wready) w_hs++;
                rvalid = rready && (d_cnt >= v.d_wait);
                bvalid = bready && (d_cnt >= v.d_wait);
                rdata  = rvalid ? v.rsp_data : 32'h0;
                rresp  = v.rsp;
                bresp  = v.rsp;
                if (rready || bready) d_cnt++;
                if (rvalid || bvalid) d_hs++;
                @(negedge clk);
            end
        end
        chk("txn_timeout", {31'd0, done}, 32'd1);
        chk("stall_cycles", stall_n, v.exp_stall);
        chk("addr_stable", {31'd0, addr_bad}, 32'd0);
        chk("addr_handshakes", a_hs, 32'd1);
        chk("resp_handshakes", d_hs, 32'd1);
        if (!v.web) begin
            chk("w_handshakes", w_hs, 32'd1);
            chk("wdata_wlast", {31'd0, data_bad}, 32'd0);
            chk("wstrb", {28'd0, strb_seen}, {28'd0, v.exp_strb});
        end else begin
            exp_rdata = v.rsp_data;
        end
        chk("done_rdata", cpu_rdata, exp_rdata);
        chk("done_resp_err", {31'd0, resp_err}, {31'd0, v.exp_err});
        cpu_ceb = 1;
        idle_slave();
        @(negedge clk); #1;
        chk("after_done_resp_err", {31'd0, resp_err}, 32'd0);
        chk("after_done_stall", {31'd0, cpu_stall}, 32'd0);
    endtask

    initial begin
        //           web addr          wdat          bweb     rsp_data      rsp    ah wh dw st strb     err
        vec[0] = '{1'b1, 32'h0001_0004, 32'h0,       4'b1111, 32'hDEADBEEF, 2'b00, 1, 1, 0, 3, 4'b0000, 1'b0};
        vec[1] = '{1'b0, 32'h0002_0000, 32'h1234_5678, 4'b1100, 32'h0,      2'b00, 3, 1, 0, 6, 4'b0011, 1'b0};
        vec[2] = '{1'b1, 32'h0000_0100, 32'h0,       4'b1111, 32'hCAFEF00D, 2'b10, 1, 1, 0, 3, 4'b0000, 1'b1};
        vec[3] = '{1'b0, 32'h0000_0008, 32'hA5A5_A5A5, 4'b0000, 32'h0,      2'b11, 1, 2, 2, 7, 4'b1111, 1'b1};
        vec[4] = '{1'b1, 32'h0000_FFFC, 32'h0,       4'b1111, 32'h0BADF00D, 2'b00, 5, 1, 5, 12, 4'b0000, 1'b0};
        vec[5] = '{1'b0, 32'h0000_0040, 32'h0F0F_0F0F, 4'b0110, 32'h0,      2'b00, 1, 1, 0, 4, 4'b1001, 1'b0};

        rst = 1; cpu_ceb = 1; cpu_web = 1; cpu_bweb = 4'hF; cpu_addr = 0; cpu_wdata = 0;
        rid = 0; bid = 0; rlast = 1;
        idle_slave();
        exp_rdata = 0;
        #2;
        chk("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("const_ar", {16'd0, arlen, 1'b0, arsize, arburst, 2'b00}, {16'd0, 8'd0, 1'b0, 3'b010, 2'b01, 2'b00});
        chk("const_aw", {16'd0, awlen, 1'b0, awsize, awburst, 2'b00}, {16'd0, 8'd0, 1'b0, 3'b010, 2'b01, 2'b00});
        chk("const_ids", {24'd0, arid, awid}, {24'd0, 4'd1, 4'd1});
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_txn(vec[i]);

        // Request held low through DONE and one more cycle: DONE ignores it, IDLE takes it again.
        begin
            int ar_n = 0;
            cpu_web = 1; cpu_addr = 32'h0000_1000; cpu_ceb = 0;
            arready = 1; rvalid = 1; rdata = 32'h1111_1111; rresp = 0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (arvalid) ar_n++;
                if (k == 3) begin
                    chk("hold_done_stall", {31'd0, cpu_stall}, 32'd0);
                    chk("hold_one_ar", ar_n, 32'd1);
                    cpu_addr = 32'h0000_2000;
                end
                if (k == 4) chk("hold_idle_stall", {31'd0, cpu_stall}, 32'd1);
                if (k == 5) begin
                    chk("hold_second_araddr", araddr, 32'h0000_2000);
                    cpu_ceb = 1;
                end
                if (k == 9) chk("hold_two_ar", ar_n, 32'd2);
                @(negedge clk);
            end
            exp_rdata = 32'h1111_1111;
            chk("hold_rdata", cpu_rdata, exp_rdata);
            idle_slave();
        end

        // Asynchronous reset while W is outstanding.
        cpu_web = 0; cpu_addr = 32'h0000_3000; cpu_wdata = 32'h7777_7777; cpu_bweb = 0; cpu_ceb = 0;
        awready = 1; wready = 0;
        #1; @(negedge clk); #1;
        @(negedge clk); #1;
        chk("pre_rst_wvalid", {31'd0, wvalid}, 32'd1);
        rst = 1; cpu_ceb = 1;
        #1;
        chk("async_rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("async_rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("async_rst_valids", {28'd0, arvalid, awvalid, rready, bready}, 32'd0);
        chk("async_rst_rdata", cpu_rdata, 32'd0);
        exp_rdata = 0;
        idle_slave();
        @(negedge clk);
        rst = 0;
        @(negedge clk); #1;
        chk("post_rst_idle_stall", {31'd0, cpu_stall}, 32'd0);
        do_txn(vec[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_dm_axi_master.md
Name: cpu_dm_axi_master

Overview:
- Downstream neighbour of the CPU core's data-memory port.
- Converts the core's SRAM-style DM request (CEB/WEB/BWEB, active-low) into single-beat AXI4 read or write transactions.
- Returns load data and drives the core's stall input until each transaction completes.
- Sits between the CPU and the AXI interconnect; one instance per CPU data port.

Parameters:
- ID_WIDTH, 4, width of AXI ID fields
- MASTER_ID, 4'd1, constant driven on ARID/AWID
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; 32 is the only supported value

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cpu_ceb  in  1  request enable, active-low
- cpu_web  in  1  0 = write, 1 = read
- cpu_bweb  in  4  per-byte write enable, active-low
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data
- cpu_stall  out  1  hold pipeline
- resp_err  out  1  one-cycle pulse on non-OKAY response
- arid  out  ID_WIDTH  read address channel
- araddr  out  32  read address channel
- arlen  out  8  read address channel
- arsize  out  3  read address channel
- arburst  out  2  read address channel
- arvalid  out  1  read address channel
- arready  in  1  read address channel
- rid  in  ID_WIDTH  read data channel
- rdata  in  32  read data channel
- rresp  in  2  read data channel
- rlast  in  1  read data channel
- rvalid  in  1  read data channel
- rready  out  1  read data channel
- awid  out  ID_WIDTH  write address channel
- awaddr  out  32  write address channel
- awlen  out  8  write address channel
- awsize  out  3  write address channel
- awburst  out  2  write address channel
- awvalid  out  1  write address channel
- awready  in  1  write address channel
- wdata  out  32  write data channel
- wstrb  out  4  write data channel
- wlast  out  1  write data channel
- wvalid  out  1  write data channel
- wready  in  1  write data channel
- bid  in  ID_WIDTH  write response channel
- bresp  in  2  write response channel
- bvalid  in  1  write response channel
- bready  out  1  write response channel

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
- Reset (async, immediate): state=IDLE; all *valid, rready, bready, resp_err = 0; cpu_rdata = 0; latched addr/data/strb = 0.
- Constant fields: arlen/awlen = 0; arsize/awsize = 3'b010; arburst/awburst = 2'b01 (INCR); wlast = 1 whenever wvalid = 1; arid/awid = MASTER_ID.
- IDLE:
  - cpu_ceb == 0 is a request; latch cpu_addr, cpu_wdata, and wstrb = ~cpu_bweb.
  - cpu_web == 1 → RD_ADDR, else → WR_ADDR.
  - Requests are accepted only in IDLE.
- RD_ADDR: arvalid = 1; on arready → RD_DATA.
- RD_DATA: rready = 1; on rvalid → capture rdata into cpu_rdata; resp_err = (rresp != 0) registered into DONE; → DONE.
- WR_ADDR: awvalid = 1; on awready → WR_DATA.
- WR_DATA: wvalid = 1; on wready → WR_RESP.
- WR_RESP: bready = 1; on bvalid → DONE; resp_err as above using bresp.
- DONE: one cycle, → IDLE unconditionally. A request still asserted during DONE is ignored; it is the same request the core is releasing.
- cpu_stall (combinational) = (state == IDLE && !cpu_ceb) || state ∉ {IDLE, DONE}.
  - Stall rises in the same cycle the request appears and falls in DONE.
- Latency, all readies high:
  - Read: stall high 3 cycles (IDLE, RD_ADDR, RD_DATA); data valid on cpu_rdata in DONE.
  - Write: stall high 4 cycles.
- cpu_rdata holds its value until the next read capture.
- Valid stability: once a valid is asserted it is held, with address/data stable, until its ready is sampled high. Ready arriving the same cycle valid rises completes the handshake.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE; there is no pipelining.
- rid/bid are not checked; rlast is ignored (single beat).
- cpu_wdata is sent unshifted; byte lanes are selected by wstrb only.

Decomposition:
- Shared package axi_pkg:
  - burst/size/resp constants: BURST_INCR, SIZE_4B, RESP_OKAY, RESP_SLVERR, RESP_DECERR
  - state enum typedef
- No sub-module needed; a single FSM with registered channel outputs is sufficient.

Test Plan:
1. Read, ARREADY=RVALID=1 immediately, rdata=32'hDEADBEEF at addr 32'h0001_0004 → araddr=32'h0001_0004; stall high exactly 3 cycles; cpu_rdata=32'hDEADBEEF in DONE; resp_err=0.
2. Write addr 32'h0002_0000, data 32'h1234_5678, cpu_bweb=4'b1100, awready delayed 3 cycles → awvalid held 3 cycles with stable awaddr; wstrb=4'b0011; wlast=1; stall released only after bvalid.
3. Read with rresp=2'b10 → resp_err pulses for exactly 1 cycle in DONE; cpu_rdata still updated; stall released.
4. cpu_ceb held low through DONE and one further cycle → exactly one AR issued for the first request; a second AR issues only for the request seen in IDLE after DONE.
5. Assert rst while in WR_DATA with wvalid=1 → wvalid, cpu_stall (with ceb high) and state return to reset values asynchronously; a subsequent read completes normally.
6. arready and rvalid both stalled 5 cycles each → araddr stable throughout; no duplicate handshake; total stall = 12 cycles.
